bound_flasher_monitor: RTL
==========================

BOUND_FLASHER_MONITOR -- requirements
Module: bound_flasher_monitor

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of cycle_count and err_count.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 led_in  input  16  SHALL be the flasher's binary LED position value, sampled every clk.
REQ-005 flick_n  input  1  SHALL be the active-low flick request seen by the flasher, sampled every clk.
REQ-006 phase  output  3  SHALL give the current expected segment, 0-5, or 7 when idle.
REQ-007 busy  output  1  SHALL be high while a sequence is being tracked.
REQ-008 seq_done  output  1  SHALL be a one-cycle pulse when a full legal sequence completes.
REQ-009 err  output  1  SHALL be a one-cycle pulse on any illegal transition.
REQ-010 err_code  output  2  SHALL be 01 wrong direction, 10 jump or hold, 11 out of range; valid with err, held otherwise.
REQ-011 abort  output  1  SHALL be a one-cycle pulse when led_in drops to 0 mid-sequence without a legal path.
REQ-012 cycle_count  output  CNT_W  SHALL count seq_done pulses.
REQ-013 err_count  output  CNT_W  SHALL count err pulses.

Function
REQ-014 Segment table SHALL be: 0 up 0->15; 1 down 15->5; 2 up 5->10; 3 down 10->0; 4 up 0->5; 5 down 5->0.
REQ-015 Registered copies prev_led (16b) and prev_flick_n SHALL be captured every cycle; all checks SHALL compare led_in against prev_led.
REQ-016 FSM states SHALL be IDLE and TRACK; in IDLE phase=7 and busy=0.
REQ-017 IDLE: led_in==0 -> stay IDLE. led_in==1 with prev_led==0 -> TRACK, phase=0. Any other value -> err, code 10 if led_in<=15, else code 11; stay IDLE.
REQ-018 TRACK, up segment: led_in==prev_led+1 is legal; if led_in equals the segment max, phase SHALL advance by 1 on the same edge.
REQ-019 TRACK, down segment: led_in==prev_led-1 is legal; if led_in equals the segment min, phase SHALL advance by 1, except in phase 5, which SHALL pulse seq_done and go IDLE.
REQ-020 Kickback: in down phase 3 or 5, led_in==prev_led+1 with prev_led in {0,5} and prev_flick_n==0 SHALL be legal, and phase SHALL decrement by 1.
REQ-021 In TRACK, led_in>15 SHALL raise err with code 11.
REQ-022 In TRACK, a step of ±1 in the direction opposite the segment that is not a legal kickback SHALL raise err with code 01.
REQ-023 In TRACK, led_in==0 with prev_led>1 SHALL pulse abort with no err and go IDLE.
REQ-024 In TRACK, any other step (hold or |delta|>1) SHALL raise err with code 10.
REQ-025 Every err or abort in TRACK SHALL return the FSM to IDLE on the same edge (resynchronise).
REQ-026 Check priority SHALL be: out of range, then abort, then legal step, then kickback, then direction, then jump.
REQ-027 cycle_count and err_count SHALL saturate at all-ones and never wrap.
REQ-028 seq_done, err and abort SHALL be registered outputs, asserted the cycle after the offending sample edge, mutually exclusive.

Reset
REQ-029 Reset SHALL asynchronously force: FSM IDLE, phase=7, busy=0, seq_done=0, err=0, abort=0, err_code=00, cycle_count=0, err_count=0, prev_led=0, prev_flick_n=1.
REQ-030 Reset asserted mid-sequence SHALL discard tracking with no err or abort pulse; the monitor SHALL resume only from a fresh 0->1 start.

Verification
REQ-031 Full legal sequence 0..15..5..10..0..5..0, one step per clk, flick_n=1 -> phases 0-5 in order, one seq_done, cycle_count=1, err_count=0.
REQ-032 In phase 3, LED 6,5 with flick_n=0 at 5, then 6 -> no err, phase=2; then sequence completes normally -> seq_done.
REQ-033 In phase 0, LED 7 then 9 -> err with code 10, IDLE, err_count=1.
REQ-034 In phase 2, LED 8 then 7 with flick_n=1 -> err with code 01; led_in=16 in phase 0 -> err with code 11.
REQ-035 In phase 1, LED 12 then 0 -> abort, no err, IDLE; reset pulse mid phase 4 -> all outputs at reset values.
REQ-036 Force 2^CNT_W+3 errors -> err_count holds at all-ones.

Source files
------------

// File: rtl/bound_flasher_monitor_if.sv
// Monitor-side view of the bound flasher: sampled LED/flick inputs plus checker results.
interface bound_flasher_monitor_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic [15:0]      led_in;
    logic             flick_n;
    logic [2:0]       phase;
    logic             busy;
    logic             seq_done;
    logic             err;
    logic [1:0]       err_code;
    logic             abort;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output led_in, flick_n,
        input  phase, busy, seq_done, err, err_code, abort, cycle_count, err_count
    );

    modport slave (
        input  led_in, flick_n,
        output phase, busy, seq_done, err, err_code, abort, cycle_count, err_count
    );
endinterface

// File: rtl/bound_flasher_monitor.sv
// Passive checker for the bound flasher: tracks the six-segment LED walk, flags
// illegal steps, aborts and completed sequences, and keeps saturating tallies.
module bound_flasher_monitor #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bound_flasher_monitor_if.slave mon
);
    typedef enum logic {IDLE, TRACK} state_e;

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [15:0]      prev_led_q;
    logic             prev_flick_n_q;
    logic             seq_done_q, seq_done_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [16:0]      led_x, prev_x;
    logic             step_up, step_dn, seg_up, kick;
    logic [15:0]      seg_end;

    // 17-bit compares so 0xFFFF+1 and 0-1 never alias onto legal values
    assign led_x   = {1'b0, mon.led_in};
    assign prev_x  = {1'b0, prev_led_q};
    assign step_up = (led_x == prev_x + 17'd1);
    assign step_dn = (led_x + 17'd1 == prev_x);
    assign seg_up  = ~phase_q[0];
    assign kick    = ((phase_q == 3'd3) || (phase_q == 3'd5)) && step_up &&
                     ((prev_led_q == 16'd0) || (prev_led_q == 16'd5)) && !prev_flick_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            prev_led_q     <= '0;
            prev_flick_n_q <= 1'b1;
            seq_done_q     <= 1'b0;
            err_q          <= 1'b0;
            abort_q        <= 1'b0;
            err_code_q     <= '0;
            cycle_cnt_q    <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            prev_led_q     <= mon.led_in;
            prev_flick_n_q <= mon.flick_n;
            seq_done_q     <= seq_done_d;
            err_q          <= err_d;
            abort_q        <= abort_d;
            err_code_q     <= err_code_d;
            cycle_cnt_q    <= cycle_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        seq_done_d = 1'b0;
        err_d      = 1'b0;
        abort_d    = 1'b0;
        err_code_d = err_code_q;
        case (phase_q)
            3'd0:    seg_end = 16'd15;
            3'd1:    seg_end = 16'd5;
            3'd2:    seg_end = 16'd10;
            3'd4:    seg_end = 16'd5;
            default: seg_end = 16'd0;
        endcase

        case (state_q)
            IDLE: begin
                if (mon.led_in == 16'd0) begin
                    state_d = IDLE;
                end else if (mon.led_in == 16'd1 && prev_led_q == 16'd0) begin
                    state_d = TRACK;
                    phase_d = 3'd0;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = (mon.led_in <= 16'd15) ? 2'b10 : 2'b11;
                end
            end
            TRACK: begin
                // ordering below is the check priority; every failure resynchronises to IDLE
                if (mon.led_in > 16'd15) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                    state_d    = IDLE;
                end else if (mon.led_in == 16'd0 && prev_led_q > 16'd1) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if ((seg_up && step_up) || (!seg_up && step_dn)) begin
                    if (mon.led_in == seg_end) begin
                        if (phase_q == 3'd5) begin
                            seq_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end
                end else if (kick) begin
                    phase_d = phase_q - 3'd1;
                end else if (step_up || step_dn) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = IDLE;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cycle_cnt_d = cycle_cnt_q;
        if (seq_done_d && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_comb begin
        mon.phase = (state_q == TRACK) ? phase_q : 3'd7;
        mon.busy  = (state_q == TRACK);
    end

    assign mon.seq_done    = seq_done_q;
    assign mon.err         = err_q;
    assign mon.abort       = abort_q;
    assign mon.err_code    = err_code_q;
    assign mon.cycle_count = cycle_cnt_q;
    assign mon.err_count   = err_cnt_q;
endmodule
